// File: rtl/button_event_classifier.sv
// Classifies a debounced, clk-synchronous button level into short, long and
// double press gestures, each reported as a single registered one-cycle pulse.
module button_event_classifier #(
  parameter int unsigned LONG_TICKS = 1000000,
  parameter int unsigned GAP_TICKS  = 500000,
  parameter int unsigned CNT_W      = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btn_in,
  output logic short_press,
  output logic long_press,
  output logic long_hold,
  output logic double_press,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HELD,
    WAIT_GAP,
    PRESS2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic             btn_q;

  // busy and long_hold are updated on every transition so they track the
  // registered state without a separate decode stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      btn_q        <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      long_hold    <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      btn_q        <= btn_in;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      if (!enable) begin
        state_q   <= IDLE;
        count_q   <= '0;
        long_hold <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            long_hold <= 1'b0;
            if (btn_in && !btn_q) begin
              state_q <= PRESS1;
              count_q <= CNT_ONE;
              busy    <= 1'b1;
            end else begin
              busy <= 1'b0;
            end
          end
          PRESS1: begin
            // A falling level takes priority over reaching the long threshold.
            if (!btn_in) begin
              state_q <= WAIT_GAP;
              count_q <= CNT_ONE;
            end else if (count_q == LONG_LAST) begin
              state_q    <= LONG_HELD;
              long_press <= 1'b1;
              long_hold  <= 1'b1;
            end else begin
              count_q <= count_q + CNT_ONE;
            end
          end
          LONG_HELD: begin
            if (!btn_in) begin
              state_q   <= IDLE;
              long_hold <= 1'b0;
              busy      <= 1'b0;
            end
          end
          WAIT_GAP: begin
            if (btn_in) begin
              state_q <= PRESS2;
            end else if (count_q == GAP_LAST) begin
              state_q     <= IDLE;
              short_press <= 1'b1;
              busy        <= 1'b0;
            end else begin
              count_q <= count_q + CNT_ONE;
            end
          end
          PRESS2: begin
            if (!btn_in) begin
              state_q      <= IDLE;
              double_press <= 1'b1;
              busy         <= 1'b0;
            end
          end
          default: begin
            state_q   <= IDLE;
            long_hold <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/button_event_classifier.md
Name: button_event_classifier

Overview:
- Consumes the clean, clk-synchronous level from the debouncer (its debounce_out) and classifies each button gesture as a short press, long press or double press.
- Emits one single-cycle pulse per gesture.
- Sits directly downstream of the debouncer and feeds control logic (mode select, menu step) in the same clock domain.
- Purely sequential: a 5-state FSM plus one shared tick counter.

Parameters:
- LONG_TICKS, default 1000000: consecutive high samples of btn_in that constitute a long press; must be >= 2.
- GAP_TICKS, default 500000: consecutive low samples after a first release within which a second press must start to form a double press; must be >= 2.
- CNT_W, default 21: counter width; must satisfy 2^CNT_W > max(LONG_TICKS, GAP_TICKS).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = classify; 0 = FSM held in IDLE, no pulses.
- btn_in  input  1  debounced button level, already synchronous to clk; no synchroniser inside.
- short_press  output  1  one-cycle pulse: single press, released before LONG_TICKS, no second press within GAP_TICKS.
- long_press  output  1  one-cycle pulse: button held LONG_TICKS samples.
- long_hold  output  1  level, high while in LONG_HELD.
- double_press  output  1  one-cycle pulse on release of a second press.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock, reset and register reset values:
  - Interface is as decided: one clock, clk; reset is synchronous and active-high.
  - All outputs are registered.
  - Reset (sampled on clk edge) sets: state = IDLE, count = 0, btn_q = 1, all outputs 0.
  - Reset wins over every other condition, including mid-gesture; no pulse is emitted for an aborted gesture.
- btn_q holds the previous-cycle btn_in. Its reset value of 1 means a button held through reset is ignored until it has been seen low once.
- States and transitions (evaluated each cycle when enable = 1):
  - IDLE:
    - btn_in = 1 and btn_q = 0: go to PRESS1, count <= 1.
    - Otherwise stay.
  - PRESS1:
    - btn_in = 1 and count == LONG_TICKS-1: go to LONG_HELD, long_press pulses next cycle.
    - btn_in = 1 otherwise: count++.
    - btn_in = 0: go to WAIT_GAP, count <= 1.
  - LONG_HELD:
    - long_hold = 1.
    - btn_in = 0: go to IDLE, no further pulse.
  - WAIT_GAP:
    - btn_in = 1: go to PRESS2.
    - btn_in = 0 and count == GAP_TICKS-1: go to IDLE, short_press pulses.
    - btn_in = 0 otherwise: count++.
  - PRESS2:
    - btn_in = 0: go to IDLE, double_press pulses.
    - No long detection on the second press, however long it is held.
- Latency:
  - long_press is high in the cycle after the edge that took the LONG_TICKS-th consecutive high sample.
  - short_press is high in the cycle after the GAP_TICKS-th consecutive low sample.
  - double_press is high in the cycle after the first low sample in PRESS2.
- Pulses:
  - Each pulse is exactly 1 cycle wide.
  - At most one of short_press, long_press, double_press is high in any cycle.
  - Exactly one pulse per completed gesture.
- Counter:
  - Unsigned, CNT_W bits.
  - Compared only against LONG_TICKS-1 or GAP_TICKS-1, so it never wraps.
  - Holds its value in IDLE, LONG_HELD and PRESS2.
- enable = 0:
  - Next state = IDLE, count = 0, pulses suppressed.
  - long_hold and busy go to 0 the next cycle.
  - btn_q keeps tracking btn_in.
  - Re-enabling with the button held gives no press until a release is seen.
- Simultaneous boundary events:
  - btn_in falling on the same edge where PRESS1 reaches LONG_TICKS-1: the falling level wins (btn_in = 0 is checked first), giving WAIT_GAP, not long.
  - btn_in rising on the sample that would reach GAP_TICKS-1 in WAIT_GAP: go to PRESS2 (double), not short.

Test Plan:
- Parameters for all scenarios: LONG_TICKS=8, GAP_TICKS=5.
- Short press: reset, then btn_in high 3 cycles, then low thereafter -> exactly one short_press pulse, 5 cycles after the first low sample; no other pulses; busy then returns to 0.
- Long press: btn_in high 20 cycles -> long_press pulses once, in the cycle after the 8th high sample; long_hold high until the cycle after release; no short_press on release.
- Double press: high 3, low 2, high 4, low -> one double_press, in the cycle after the second release; no short_press; boundary variant low 4 then high still yields double_press.
- Boundary timing:
  - High exactly 7 cycles then low -> short path (no long_press).
  - High exactly 8 cycles -> long_press.
  - Low exactly 5 cycles after the first release -> short_press fires and the next press starts a new gesture.
- Reset and enable:
  - Assert reset for 1 cycle in the middle of PRESS1 while btn_in stays high -> no pulses; no new press until btn_in goes low then high.
  - Same behaviour when enable is dropped mid-WAIT_GAP: no short_press is emitted.
